fifo_push_arbiter: RTL and testbench

FIFO_PUSH_ARBITER -- requirements
Module: fifo_push_arbiter

---
 rtl/fifo_push_arbiter.sv | 161 ++++++++++++++++
 tb/tb_fifo_push_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter
//   Arbitrates NUM_REQ push requesters onto a single FIFO write port.
//   A three-state FSM (IDLE -> PUSH -> SETTLE) issues at most one push
//   every three cycles. The extra SETTLE cycle gives fifo_full time to
//   reflect the push before the next arbitration.
//
//   Build option:
//     FIFO_ARB_FIXED_PRIO_EN defined   -> fixed priority, lowest index wins
//     FIFO_ARB_FIXED_PRIO_EN undefined -> round-robin (default)
//
// Ports
//   clk       in   single clock, rising edge
//   reset     in   asynchronous, active-low reset
//   req       in   [NUM_REQ]             per-requester push request (level)
//   req_data  in   [NUM_REQ*DATA_WIDTH]  requester i data at [i*DATA_WIDTH +: DATA_WIDTH]
//   fifo_full in   FIFO full flag, sampled only in IDLE
//   push      out  FIFO push strobe (registered), high for the PUSH cycle
//   data_in   out  [DATA_WIDTH] FIFO write data (registered), held until next grant
//   gnt       out  [NUM_REQ] one-hot acknowledge to the winner (registered)
//   busy      out  high whenever the FSM is not in IDLE (registered)

module fifo_push_arbiter #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic                          fifo_full,
   output logic                          push,
   output logic [DATA_WIDTH-1:0]         data_in,
   output logic [NUM_REQ-1:0]            gnt,
   output logic                          busy
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);

   typedef enum logic [1:0] {
      IDLE,
      PUSH,
      SETTLE
   } state_t;

   state_t                  state;
   logic                    found;
   logic [IDX_W-1:0]        win_idx;
   logic [IDX_W-1:0]        cand;
   logic [NUM_REQ-1:0]      win_onehot;
   logic [DATA_WIDTH-1:0]   win_data;

`ifndef FIFO_ARB_FIXED_PRIO_EN
   logic [IDX_W-1:0]        last_winner;
`endif

   // ------------------------------------------------------------------
   // Winner selection
   // ------------------------------------------------------------------
`ifdef FIFO_ARB_FIXED_PRIO_EN
   // Lowest-index active requester always wins.
   always_comb begin
      found   = 1'b0;
      win_idx = '0;
      cand    = '0;
      for (int unsigned off = 0; off < NUM_REQ; off++) begin
         cand = IDX_W'(off);
         if (!found && req[cand]) begin
            found   = 1'b1;
            win_idx = cand;
         end
      end
   end
`else
   // Search starts one past the previous winner and wraps, so every
   // persistent requester is served within NUM_REQ arbitrations.
   always_comb begin
      found   = 1'b0;
      win_idx = '0;
      cand    = '0;
      for (int unsigned off = 0; off < NUM_REQ; off++) begin
         cand = IDX_W'((32'(last_winner) + 32'd1 + off) % NUM_REQ);
         if (!found && req[cand]) begin
            found   = 1'b1;
            win_idx = cand;
         end
      end
   end
`endif

   // One-hot grant vector and data mux for the selected requester.
   always_comb begin
      win_onehot = '0;
      win_data   = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (win_idx == IDX_W'(i)) begin
            win_onehot[i] = found;
            win_data      = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // ------------------------------------------------------------------
   // FSM with registered outputs
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         push    <= 1'b0;
         gnt     <= '0;
         data_in <= '0;
         busy    <= 1'b0;
`ifndef FIFO_ARB_FIXED_PRIO_EN
         // Pointing at the last requester makes requester 0 first after reset.
         last_winner <= IDX_W'(NUM_REQ - 1);
`endif
      end else begin
         case (state)
            IDLE: begin
               // fifo_full is only looked at here; a grant already issued
               // is never withdrawn by a later full flag or req drop.
               if (found && !fifo_full) begin
                  state   <= PUSH;
                  push    <= 1'b1;
                  gnt     <= win_onehot;
                  data_in <= win_data;
                  busy    <= 1'b1;
`ifndef FIFO_ARB_FIXED_PRIO_EN
                  last_winner <= win_idx;
`endif
               end
            end
            PUSH: begin
               state <= SETTLE;
               push  <= 1'b0;
               gnt   <= '0;
            end
            SETTLE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               push  <= 1'b0;
               gnt   <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Structural invariants
   // ------------------------------------------------------------------
   a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!reset)
                                    $onehot0(gnt));
   a_push_gnt    : assert property (@(posedge clk) disable iff (!reset)
                                    push == (gnt != '0));
   a_busy_state  : assert property (@(posedge clk) disable iff (!reset)
                                    busy == (state != IDLE));

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed testbench for fifo_push_arbiter (NUM_REQ=4, DATA_WIDTH=32).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.

module tb_fifo_push_arbiter;

   localparam int unsigned NR = 4;
   localparam int unsigned DW = 32;

   logic               clk;
   logic               reset;
   logic [NR-1:0]      req;
   logic [NR*DW-1:0]   req_data;
   logic               fifo_full;
   logic               push;
   logic [DW-1:0]      data_in;
   logic [NR-1:0]      gnt;
   logic               busy;

   int unsigned n_checks;
   int unsigned n_fail;

   fifo_push_arbiter #(
      .NUM_REQ   (NR),
      .DATA_WIDTH(DW)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .req_data (req_data),
      .fifo_full(fifo_full),
      .push     (push),
      .data_in  (data_in),
      .gnt      (gnt),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_data(input int unsigned idx, input logic [DW-1:0] val);
      req_data[idx*DW +: DW] = val;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_push"}, 64'(push), 64'd0);
      check({tag, "_gnt"},  64'(gnt),  64'd0);
   endtask

   // Hard stop in case the run ever stalls.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   logic [NR-1:0] exp_gnt [5];
   logic [DW-1:0] exp_dat [5];

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      req       = '0;
      req_data  = '0;
      fifo_full = 1'b0;
      reset     = 1'b1;
      #2 reset  = 1'b0;

      // ---------------- reset state ----------------
      step(2);
      check("rst_push",  64'(push),    64'd0);
      check("rst_gnt",   64'(gnt),     64'd0);
      check("rst_data",  64'(data_in), 64'd0);
      check("rst_busy",  64'(busy),    64'd0);
      reset = 1'b1;

      // ---------------- single request, data 50 ----------------
      req = 4'b0001;
      set_data(0, 32'd50);
      step(1);
      check("single_push", 64'(push),    64'd1);
      check("single_gnt",  64'(gnt),     64'h1);
      check("single_data", 64'(data_in), 64'd50);
      check("single_busy", 64'(busy),    64'd1);
      req = '0;
      step(1);
      check_idle_outputs("single_settle");
      check("single_settle_busy", 64'(busy),    64'd1);
      check("single_hold_data",   64'(data_in), 64'd50);
      step(1);
      check("single_idle_busy", 64'(busy), 64'd0);
      check_idle_outputs("single_idle");

      // ---------------- all requesting, round-robin ----------------
      reset = 1'b0;
      step(1);
      reset = 1'b1;
      for (int unsigned i = 0; i < NR; i++) set_data(i, 32'(10 * (i + 1)));
`ifdef FIFO_ARB_FIXED_PRIO_EN
      for (int k = 0; k < 5; k++) begin
         exp_gnt[k] = 4'b0001;
         exp_dat[k] = 32'd10;
      end
`else
      exp_gnt[0] = 4'b0001; exp_dat[0] = 32'd10;
      exp_gnt[1] = 4'b0010; exp_dat[1] = 32'd20;
      exp_gnt[2] = 4'b0100; exp_dat[2] = 32'd30;
      exp_gnt[3] = 4'b1000; exp_dat[3] = 32'd40;
      exp_gnt[4] = 4'b0001; exp_dat[4] = 32'd10;
`endif
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         step(1);
         check($sformatf("rr%0d_push", k), 64'(push),    64'd1);
         check($sformatf("rr%0d_gnt",  k), 64'(gnt),     64'(exp_gnt[k]));
         check($sformatf("rr%0d_data", k), 64'(data_in), 64'(exp_dat[k]));
         step(1);
         check_idle_outputs($sformatf("rr%0d_settle", k));
         step(1);
         check_idle_outputs($sformatf("rr%0d_idle", k));
         check($sformatf("rr%0d_idle_busy", k), 64'(busy), 64'd0);
      end
      req = '0;

      // ---------------- fifo_full holds off request 2 ----------------
      fifo_full = 1'b1;
      req       = 4'b0100;
      set_data(2, 32'd33);
      for (int k = 0; k < 5; k++) begin
         step(1);
         check_idle_outputs($sformatf("full%0d", k));
         check($sformatf("full%0d_busy", k), 64'(busy), 64'd0);
      end
      fifo_full = 1'b0;
      step(1);
      check("unfull_push", 64'(push),    64'd1);
      check("unfull_gnt",  64'(gnt),     64'h4);
      check("unfull_data", 64'(data_in), 64'd33);
      req = '0;
      step(2);

      // ---------------- fifo_full rises during PUSH of requester 1 ----------------
      req = 4'b0010;
      set_data(1, 32'd70);
      step(1);
      check("late_full_push0", 64'(push),    64'd1);
      check("late_full_gnt",   64'(gnt),     64'h2);
      check("late_full_data",  64'(data_in), 64'd70);
      fifo_full = 1'b1;
      #1;
      check("late_full_push1", 64'(push), 64'd1);
      for (int k = 0; k < 6; k++) begin
         step(1);
         check_idle_outputs($sformatf("late_full_hold%0d", k));
      end
      check("late_full_keep_data", 64'(data_in), 64'd70);
      fifo_full = 1'b0;
      req       = '0;
      step(1);

      // ---------------- reset asserted mid-PUSH ----------------
      req = 4'b0010;
      set_data(1, 32'd90);
      step(1);
      check("midrst_push_before", 64'(push),    64'd1);
      check("midrst_data_before", 64'(data_in), 64'd90);
      reset = 1'b0;
      #1;
      check("midrst_push", 64'(push),    64'd0);
      check("midrst_gnt",  64'(gnt),     64'd0);
      check("midrst_data", 64'(data_in), 64'd0);
      check("midrst_busy", 64'(busy),    64'd0);
      step(1);
      reset = 1'b1;
      req   = 4'b0011;
      set_data(0, 32'd55);
      step(1);
      check("postrst_gnt",  64'(gnt),     64'h1);
      check("postrst_data", 64'(data_in), 64'd55);
      req = '0;
      step(2);

      // ---------------- req 0101 held ----------------
      // Last winner is requester 0 here.
      req = 4'b0101;
      for (int k = 0; k < 4; k++) begin
         step(1);
`ifdef FIFO_ARB_FIXED_PRIO_EN
         check($sformatf("prio%0d_gnt", k), 64'(gnt), 64'h1);
`else
         check($sformatf("rr0101_%0d_gnt", k), 64'(gnt), (k % 2 == 0) ? 64'h4 : 64'h1);
`endif
         step(2);
      end
      req = '0;
      step(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
